// File: rtl/tp_pkg.sv
// rtl/tp_pkg.sv - shared types, defaults and round-robin pick for the multiplier arbiter
package tp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int N_BIT_DEF = 4;
    localparam int NREQ_DEF  = 3;
    localparam int MAX_REQ   = 32;

    // Returns the first set index at or after ptr (wrapping mod n), or -1 when vec is empty.
    function automatic int find_first_from(input logic [MAX_REQ-1:0] vec, input int ptr, input int n);
        int idx;
        find_first_from = -1;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (vec[idx[4:0]]) find_first_from = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - request/response bundle between requesters and the multiplier arbiter
interface mul_arbiter_if
    import tp_pkg::*;
#(
    parameter int N_BIT = N_BIT_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int ID_W  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*N_BIT-1:0] req_a;
    logic [NREQ*N_BIT-1:0] req_b;
    logic [NREQ-1:0]       req_signed;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [2*N_BIT-1:0]    rsp_product;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy
    );
endinterface

// File: rtl/mul_arbiter_mul.sv
// rtl/mul_arbiter_mul.sv - combinational N_BIT x N_BIT array multiplier, signed or unsigned
module mul #(
    parameter int N_BIT = 4
) (
    input  logic [N_BIT-1:0]   i_a,
    input  logic [N_BIT-1:0]   i_b,
    input  logic               i_mul_type,
    output logic [2*N_BIT-1:0] o_product
);
    logic [2*N_BIT-1:0] w_ea;
    logic [2*N_BIT-1:0] w_eb;
    logic [2*N_BIT-1:0] w_acc;

    // Sign-extending to the full product width makes the truncated sum exact for signed inputs.
    always_comb begin
        w_ea  = i_mul_type ? {{N_BIT{i_a[N_BIT-1]}}, i_a} : {{N_BIT{1'b0}}, i_a};
        w_eb  = i_mul_type ? {{N_BIT{i_b[N_BIT-1]}}, i_b} : {{N_BIT{1'b0}}, i_b};
        w_acc = '0;
        for (int i = 0; i < 2*N_BIT; i++) begin
            if (w_eb[i]) w_acc = w_acc + (w_ea << i);
        end
    end

    assign o_product = w_acc;
endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sharing of one multiplier among NREQ requesters
module mul_arbiter
    import tp_pkg::*;
#(
    parameter int N_BIT = N_BIT_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_arbiter_if.slave  bus
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [N_BIT-1:0]     r_a;
    logic [N_BIT-1:0]     r_b;
    logic                 r_signed;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [2*N_BIT-1:0]   r_rsp_product;
    logic [2*N_BIT-1:0]   w_product;
    int                   w_pick;
    logic                 w_any;
    logic                 w_fire;
    logic [ID_W-1:0]      w_gid;
    logic [NREQ-1:0]      w_ready;

    assign w_pick = find_first_from(MAX_REQ'(bus.req_valid), int'(r_rr_ptr), NREQ);
    assign w_any  = (w_pick >= 0);
    assign w_gid  = ID_W'(w_pick);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            IDLE: begin
                // Grants are withheld while reset is asserted even though state already reads IDLE.
                if (rst_n && w_any) begin
                    w_ready[w_gid] = 1'b1;
                    w_state_nxt    = CALC;
                end
            end
            CALC:    w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_fire = |w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_id          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_signed      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_a      <= bus.req_a[int'(w_gid)*N_BIT +: N_BIT];
                        r_b      <= bus.req_b[int'(w_gid)*N_BIT +: N_BIT];
                        r_signed <= bus.req_signed[w_gid];
                        r_id     <= w_gid;
                        r_rr_ptr <= (w_gid == ID_W'(NREQ-1)) ? '0 : w_gid + 1'b1;
                    end
                end
                CALC: begin
                    r_rsp_product <= w_product;
                    r_rsp_id      <= r_id;
                    r_rsp_valid   <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mul #(.N_BIT(N_BIT)) u_mul (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_mul_type (r_signed),
        .o_product  (w_product)
    );

    assign bus.req_ready   = w_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_product = r_rsp_product;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed-vector bench for mul_arbiter
module tb_mul_arbiter;
    localparam int N = 4;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_arbiter_if #(.N_BIT(N), .NREQ(R)) bus ();

    mul_arbiter #(.N_BIT(N), .NREQ(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = '0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_op(input int idx, input logic [3:0] a, input logic [3:0] b, input logic s);
        bus.req_a[idx*N +: N] = a;
        bus.req_b[idx*N +: N] = b;
        bus.req_signed[idx]   = s;
    endtask

    // Drives one request through to its response; returns observed data and edges from grant to rsp_valid.
    task automatic run_one(input int idx, input logic [3:0] a, input logic [3:0] b, input logic s,
                           output logic [7:0] prod, output logic [1:0] id, output int lat);
        int w;
        set_op(idx, a, b, s);
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        bus.rsp_ready      = 1'b1;
        #1;
        w = 0;
        while (!bus.req_ready[idx] && w < 20) begin
            tick();
            w++;
        end
        tick();
        bus.req_valid = '0;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        prod = bus.rsp_product;
        id   = bus.rsp_id;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.req_valid = 3'b111;
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b want 000", bus.req_ready); end
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_valid_busy got %b/%b want 0/0", bus.rsp_valid, bus.busy);
        end
        n_vec++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_product !== 8'h00) begin
            n_err++; $display("FAIL reset_rsp got id=%0d prod=%h want 0/00", bus.rsp_id, bus.rsp_product);
        end
        clear_inputs();
    endtask

    task automatic test_basic();
        logic [7:0] p;
        logic [1:0] id;
        int lat;
        do_reset();
        set_op(0, 4'd3, 4'd5, 1'b0);
        bus.req_valid = 3'b001;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL basic_ready got %b want 001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 3'b000 || bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_calc got busy=%b ready=%b rv=%b want 1/000/0", bus.busy, bus.req_ready, bus.rsp_valid);
        end
        tick();
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 8'h0F || bus.rsp_id !== 2'd0) begin
            n_err++; $display("FAIL basic_rsp got rv=%b prod=%h id=%0d want 1/0f/0", bus.rsp_valid, bus.rsp_product, bus.rsp_id);
        end
        tick();
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL basic_done got rv=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
        end
        run_one(1, 4'hF, 4'h3, 1'b1, p, id, lat);
        n_vec++;
        if (p !== 8'hFD || id !== 2'd1 || lat !== 1) begin
            n_err++; $display("FAIL signed_f3 got prod=%h id=%0d lat=%0d want fd/1/1", p, id, lat);
        end
        run_one(1, 4'hF, 4'h3, 1'b0, p, id, lat);
        n_vec++;
        if (p !== 8'h2D || id !== 2'd1) begin n_err++; $display("FAIL unsigned_f3 got prod=%h id=%0d want 2d/1", p, id); end
    endtask

    task automatic test_boundary();
        logic [7:0] p;
        logic [1:0] id;
        int lat;
        do_reset();
        run_one(2, 4'h8, 4'h8, 1'b1, p, id, lat);
        n_vec++;
        if (p !== 8'h40 || id !== 2'd2) begin n_err++; $display("FAIL signed_m8m8 got prod=%h id=%0d want 40/2", p, id); end
        run_one(0, 4'hF, 4'hF, 1'b0, p, id, lat);
        n_vec++;
        if (p !== 8'hE1) begin n_err++; $display("FAIL unsigned_15x15 got %h want e1", p); end
        run_one(1, 4'h8, 4'h7, 1'b1, p, id, lat);
        n_vec++;
        if (p !== 8'hC8) begin n_err++; $display("FAIL signed_m8x7 got %h want c8", p); end
    endtask

    task automatic test_round_robin();
        int         gcyc[$];
        int         gidx[$];
        int         rid[$];
        logic [7:0] rprod[$];
        logic [7:0] exp_p [3];
        clear_inputs();
        set_op(0, 4'd2, 4'd3, 1'b0);
        set_op(1, 4'hF, 4'hF, 1'b1);
        set_op(2, 4'h9, 4'h2, 1'b0);
        exp_p[0] = 8'h06;
        exp_p[1] = 8'h01;
        exp_p[2] = 8'h12;
        bus.req_valid = 3'b111;
        do_reset();
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (bus.req_ready != 3'b000) begin
                gcyc.push_back(cyc);
                case (bus.req_ready)
                    3'b001:  gidx.push_back(0);
                    3'b010:  gidx.push_back(1);
                    3'b100:  gidx.push_back(2);
                    default: gidx.push_back(9);
                endcase
            end
            if (bus.rsp_valid) begin
                rid.push_back(int'(bus.rsp_id));
                rprod.push_back(bus.rsp_product);
            end
            tick();
        end
        n_vec++;
        if (gidx.size() != 5 || rid.size() != 5) begin
            n_err++; $display("FAIL rr_counts got grants=%0d rsps=%0d want 5/5", gidx.size(), rid.size());
        end
        for (int i = 0; i < 5 && i < gidx.size(); i++) begin
            n_vec++;
            if (gidx[i] != i % 3 || gcyc[i] != 3*i) begin
                n_err++; $display("FAIL rr_grant%0d got idx=%0d cyc=%0d want %0d/%0d", i, gidx[i], gcyc[i], i % 3, 3*i);
            end
        end
        for (int i = 0; i < 5 && i < rid.size(); i++) begin
            n_vec++;
            if (rid[i] != i % 3 || rprod[i] !== exp_p[i % 3]) begin
                n_err++; $display("FAIL rr_rsp%0d got id=%0d prod=%h want %0d/%h", i, rid[i], rprod[i], i % 3, exp_p[i % 3]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 4'd7, 4'd7, 1'b0);
        set_op(1, 4'd1, 4'd1, 1'b0);
        bus.req_valid = 3'b001;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 3'b010;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 8'h31 || bus.rsp_id !== 2'd0 ||
                bus.req_ready !== 3'b000 || bus.busy !== 1'b1) begin
                n_err++; $display("FAIL hold_c%0d got rv=%b prod=%h id=%0d ready=%b busy=%b want 1/31/0/000/1",
                                  i, bus.rsp_valid, bus.rsp_product, bus.rsp_id, bus.req_ready, bus.busy);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL release_same_cycle got %b want 000", bus.req_ready); end
        tick();
        n_vec++;
        if (bus.req_ready !== 3'b010 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL release_next got ready=%b rv=%b busy=%b want 010/0/0", bus.req_ready, bus.rsp_valid, bus.busy);
        end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_op(1, 4'd1, 4'd1, 1'b0);
        set_op(0, 4'd2, 4'd2, 1'b0);
        set_op(2, 4'd3, 4'd3, 1'b0);
        bus.req_valid = 3'b010;
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 3'b000) begin
            n_err++; $display("FAIL midrst_now got rv=%b busy=%b ready=%b want 0/0/000", bus.rsp_valid, bus.busy, bus.req_ready);
        end
        tick();
        n_vec++;
        if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_next got rv=%b want 0", bus.rsp_valid); end
        bus.req_valid = 3'b101;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b001 || bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_grant got ready=%b rv=%b want 001/0", bus.req_ready, bus.rsp_valid);
        end
        tick();
        bus.req_valid = '0;
        tick();
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_product !== 8'h04) begin
            n_err++; $display("FAIL midrst_rsp got rv=%b id=%0d prod=%h want 1/0/04", bus.rsp_valid, bus.rsp_id, bus.rsp_product);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
